// File: rtl/tracing_unit_param_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tracing_unit_param_if : inline val/yum link plus trace drain port
// Revision 1.0
// ---------------------------------------------------------------------------
interface tracing_unit_param_if #(
  parameter int FLIT_W = 64,
  parameter int TS_W   = 16
);
  logic [FLIT_W-1:0]      din_msg;
  logic                   din_val;
  logic                   din_yum;
  logic [FLIT_W-1:0]      dout_msg;
  logic                   dout_val;
  logic                   dout_yum;
  logic [TS_W+FLIT_W-1:0] trace_data;
  logic                   trace_val;
  logic                   trace_rdy;

  modport slave (
    input  din_msg, din_val, dout_yum, trace_rdy,
    output din_yum, dout_msg, dout_val, trace_data, trace_val
  );

  modport master (
    output din_msg, din_val, dout_yum, trace_rdy,
    input  din_yum, dout_msg, dout_val, trace_data, trace_val
  );
endinterface
`default_nettype wire

// File: rtl/tracing_unit_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tracing_unit_param : zero-latency NoC tap with framing, counters, trace FIFO
// Revision 1.0
// ---------------------------------------------------------------------------
module tracing_unit_param #(
  parameter int FLIT_W      = 64,
  parameter int LEN_LO      = 22,
  parameter int LEN_W       = 8,
  parameter int TRACE_DEPTH = 8,
  parameter int TS_W        = 16,
  parameter int CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  tracing_unit_param_if.slave  bus,
  input  logic                 trace_en,
  input  logic                 clear,
  output logic [CNT_W-1:0]     flit_cnt,
  output logic [CNT_W-1:0]     msg_cnt,
  output logic [CNT_W-1:0]     drop_cnt,
  output logic                 in_body,
  output logic                 overflow,
  output logic                 proto_err
);

  localparam int               PTR_W    = $clog2(TRACE_DEPTH);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(TRACE_DEPTH);

  typedef enum logic [0:0] {
    ST_HEADER = 1'b0,
    ST_BODY   = 1'b1
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [LEN_W-1:0]        r_rem, w_rem_nxt, w_len;
  logic [TS_W-1:0]         r_ts;
  logic [TS_W+FLIT_W-1:0]  r_mem [TRACE_DEPTH];
  logic [PTR_W-1:0]        r_wr_ptr, r_rd_ptr;
  logic [PTR_W:0]          r_count;
  logic                    w_xfer, w_hdr_xfer, w_empty, w_full;
  logic                    w_pop, w_push_req, w_push, w_drop;

  assign bus.dout_msg = bus.din_msg;
  assign bus.dout_val = bus.din_val;
  assign bus.din_yum  = bus.dout_yum;

  assign w_xfer     = bus.din_val & bus.dout_yum;
  assign w_len      = bus.din_msg[LEN_LO +: LEN_W];
  assign w_hdr_xfer = w_xfer & (r_state == ST_HEADER);
  assign in_body    = (r_state == ST_BODY);

  always_comb begin
    w_state_nxt = r_state;
    w_rem_nxt   = r_rem;
    if (w_xfer) begin
      case (r_state)
        ST_HEADER: begin
          if (w_len != '0) begin
            w_state_nxt = ST_BODY;
            w_rem_nxt   = w_len;
          end
        end
        ST_BODY: begin
          if (r_rem == LEN_W'(1)) w_state_nxt = ST_HEADER;
          else                    w_rem_nxt   = r_rem - LEN_W'(1);
        end
      endcase
    end
  end

  // Framing state survives clear so an in-flight message stays in sync.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_HEADER;
      r_rem   <= '0;
      r_ts    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_rem   <= w_rem_nxt;
      r_ts    <= r_ts + TS_W'(1);
    end
  end

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FULL_CNT);
  assign w_pop      = ~w_empty & bus.trace_rdy;
  assign w_push_req = w_hdr_xfer & trace_en;
  assign w_push     = w_push_req & (~w_full | w_pop);
  assign w_drop     = w_push_req & ~w_push;

  assign bus.trace_val  = ~w_empty;
  assign bus.trace_data = w_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wr_ptr] <= {r_ts, bus.din_msg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      flit_cnt  <= '0;
      msg_cnt   <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else if (clear) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      flit_cnt  <= '0;
      msg_cnt   <= '0;
      drop_cnt  <= '0;
      overflow  <= 1'b0;
      proto_err <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push && !w_pop)      r_count <= r_count + (PTR_W+1)'(1);
      else if (w_pop && !w_push) r_count <= r_count - (PTR_W+1)'(1);
      if (w_xfer)     flit_cnt <= flit_cnt + CNT_W'(1);
      if (w_hdr_xfer) msg_cnt  <= msg_cnt + CNT_W'(1);
      if (w_drop) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
      if (bus.dout_yum && !bus.din_val) proto_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_tracing_unit_param.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_tracing_unit_param : vector table plus FIFO scoreboard for the trace tap
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_tracing_unit_param;
  localparam int FLIT_W = 64;
  localparam int LEN_LO = 22;
  localparam int LEN_W  = 8;
  localparam int DEPTH  = 8;
  localparam int TS_W   = 16;
  localparam int CNT_W  = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             trace_en = 1'b0;
  logic             clear = 1'b0;
  logic [CNT_W-1:0] flit_cnt, msg_cnt, drop_cnt;
  logic             in_body, overflow, proto_err;

  tracing_unit_param_if #(.FLIT_W(FLIT_W), .TS_W(TS_W)) bus ();

  tracing_unit_param #(
    .FLIT_W(FLIT_W), .LEN_LO(LEN_LO), .LEN_W(LEN_W),
    .TRACE_DEPTH(DEPTH), .TS_W(TS_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .trace_en(trace_en), .clear(clear),
    .flit_cnt(flit_cnt), .msg_cnt(msg_cnt), .drop_cnt(drop_cnt),
    .in_body(in_body), .overflow(overflow), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [TS_W+FLIT_W-1:0] sb [$];
  logic [TS_W-1:0]        m_ts;
  logic [CNT_W-1:0]       m_flit, m_msg, m_drop;
  logic                   m_body, m_ovf, m_perr;
  logic [LEN_W-1:0]       m_rem;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_ts <= '0;
    else        m_ts <= m_ts + TS_W'(1);
  end

  typedef struct {
    logic             v;
    logic [LEN_W-1:0] len;
    logic             y;
    logic             rdy;
    logic             clr;
    logic             e_body;
    int               e_msg;
    int               e_flit;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [FLIT_W-1:0] mk(input int tag, input logic [LEN_W-1:0] len);
    logic [FLIT_W-1:0] r;
    r = '0;
    r[FLIT_W-1 -: 16]   = 16'(tag);
    r[15:0]             = 16'(tag) ^ 16'hBEEF;
    r[LEN_LO +: LEN_W]  = len;
    return r;
  endfunction

  task automatic m_reset();
    sb.delete();
    m_flit = '0; m_msg = '0; m_drop = '0;
    m_body = 1'b0; m_ovf = 1'b0; m_perr = 1'b0; m_rem = '0;
  endtask

  // One clock cycle: drive at edge+1, compare combinational/FIFO head at edge+3,
  // advance the reference model, then compare registered outputs at next edge+1.
  task automatic cyc(input logic v, input logic [FLIT_W-1:0] m, input logic y,
                     input logic rdy, input logic clr);
    logic xfer, hdr, pop;
    logic [LEN_W-1:0] len;
    bus.din_val = v; bus.din_msg = m; bus.dout_yum = y; bus.trace_rdy = rdy; clear = clr;
    #2;
    chk("dout_msg", 128'(bus.dout_msg), 128'(m));
    chk("dout_val", 128'(bus.dout_val), 128'(v));
    chk("din_yum", 128'(bus.din_yum), 128'(y));
    chk("trace_val", 128'(bus.trace_val), 128'(sb.size() != 0));
    if (sb.size() != 0) chk("trace_data", 128'(bus.trace_data), 128'(sb[0]));
    xfer = v & y;
    hdr  = xfer & ~m_body;
    pop  = rdy && (sb.size() != 0);
    len  = m[LEN_LO +: LEN_W];
    if (clr) begin
      sb.delete();
      m_flit = '0; m_msg = '0; m_drop = '0; m_ovf = 1'b0; m_perr = 1'b0;
    end else begin
      if (pop) void'(sb.pop_front());
      if (hdr && trace_en) begin
        if (sb.size() < DEPTH) sb.push_back({m_ts, m});
        else begin
          m_ovf = 1'b1;
          if (m_drop != '1) m_drop = m_drop + CNT_W'(1);
        end
      end
      if (xfer) m_flit = m_flit + CNT_W'(1);
      if (hdr)  m_msg  = m_msg + CNT_W'(1);
      if (y && !v) m_perr = 1'b1;
    end
    if (xfer) begin
      if (!m_body) begin
        if (len != '0) begin m_body = 1'b1; m_rem = len; end
      end else if (m_rem == LEN_W'(1)) m_body = 1'b0;
      else m_rem = m_rem - LEN_W'(1);
    end
    @(posedge clk); #1;
    chk("flit_cnt", 128'(flit_cnt), 128'(m_flit));
    chk("msg_cnt", 128'(msg_cnt), 128'(m_msg));
    chk("drop_cnt", 128'(drop_cnt), 128'(m_drop));
    chk("in_body", 128'(in_body), 128'(m_body));
    chk("overflow", 128'(overflow), 128'(m_ovf));
    chk("proto_err", 128'(proto_err), 128'(m_perr));
  endtask

  initial begin
    // v, len, y, rdy, clr, exp in_body, exp msg_cnt, exp flit_cnt
    tbl[0]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 1};
    tbl[1]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 2};
    tbl[2]  = '{1'b1, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 3};
    tbl[3]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
    tbl[4]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
    tbl[5]  = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3, 3};
    tbl[6]  = '{1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0};
    tbl[7]  = '{1'b1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1};
    tbl[8]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    tbl[9]  = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    tbl[10] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    tbl[11] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    tbl[12] = '{1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 1'b1, 1, 1};
    tbl[13] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b1, 1, 2};
    tbl[14] = '{1'b1, 8'hAA, 1'b1, 1'b0, 1'b0, 1'b0, 1, 3};
    tbl[15] = '{1'b0, 8'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1, 3};

    bus.din_val = 1'b0; bus.din_msg = '0; bus.dout_yum = 1'b0; bus.trace_rdy = 1'b0;
    m_reset();
    @(posedge clk); #1;
    chk("rst_flit_cnt", 128'(flit_cnt), 128'(0));
    chk("rst_msg_cnt", 128'(msg_cnt), 128'(0));
    chk("rst_drop_cnt", 128'(drop_cnt), 128'(0));
    chk("rst_in_body", 128'(in_body), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    chk("rst_proto_err", 128'(proto_err), 128'(0));
    chk("rst_trace_val", 128'(bus.trace_val), 128'(0));
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    trace_en = 1'b1;

    // Zero-length headers, drain, clear, then a stalled two-flit body.
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].v, mk(i + 1, tbl[i].len), tbl[i].y, tbl[i].rdy, tbl[i].clr);
      chk("tbl_in_body", 128'(in_body), 128'(tbl[i].e_body));
      chk("tbl_msg_cnt", 128'(msg_cnt), 128'(tbl[i].e_msg));
      chk("tbl_flit_cnt", 128'(flit_cnt), 128'(tbl[i].e_flit));
    end

    // Fill past depth with no drain: two drops.
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 10; i++) cyc(1'b1, mk(100 + i, 8'd0), 1'b1, 1'b0, 1'b0);
    chk("fill_drop_cnt", 128'(drop_cnt), 128'(2));
    chk("fill_overflow", 128'(overflow), 128'(1));
    chk("fill_msg_cnt", 128'(msg_cnt), 128'(10));

    // Full FIFO, push and pop in the same cycle: accepted, no drop.
    cyc(1'b1, mk(200, 8'd0), 1'b1, 1'b1, 1'b0);
    chk("fullpop_drop_cnt", 128'(drop_cnt), 128'(2));
    for (int i = 0; i < DEPTH; i++) cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
    #2;
    chk("drained_trace_val", 128'(bus.trace_val), 128'(0));
    @(posedge clk); #1;

    // Yum without valid is sticky.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("perr_set", 128'(proto_err), 128'(1));
    cyc(1'b0, '0, 1'b0, 1'b0, 1'b0);
    chk("perr_sticky", 128'(proto_err), 128'(1));

    // Clear coincident with a len=3 header: counters cleared, FSM still advances.
    cyc(1'b1, mk(300, 8'd0), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, mk(301, 8'd0), 1'b1, 1'b0, 1'b0);
    cyc(1'b1, mk(302, 8'd3), 1'b1, 1'b0, 1'b1);
    chk("clr_flit_cnt", 128'(flit_cnt), 128'(0));
    chk("clr_msg_cnt", 128'(msg_cnt), 128'(0));
    chk("clr_proto_err", 128'(proto_err), 128'(0));
    chk("clr_in_body", 128'(in_body), 128'(1));
    chk("clr_trace_val", 128'(bus.trace_val), 128'(0));

    // Asynchronous reset mid-body, then the next flit is a header.
    cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("pre_rst_perr", 128'(proto_err), 128'(1));
    bus.din_val = 1'b0; bus.dout_yum = 1'b0; clear = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_in_body", 128'(in_body), 128'(0));
    chk("arst_proto_err", 128'(proto_err), 128'(0));
    chk("arst_flit_cnt", 128'(flit_cnt), 128'(0));
    chk("arst_trace_val", 128'(bus.trace_val), 128'(0));
    m_reset();
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    cyc(1'b1, mk(400, 8'd1), 1'b1, 1'b0, 1'b0);
    chk("post_rst_hdr_body", 128'(in_body), 128'(1));
    chk("post_rst_msg_cnt", 128'(msg_cnt), 128'(1));
    cyc(1'b1, mk(401, 8'd0), 1'b1, 1'b1, 1'b0);
    chk("post_rst_body_end", 128'(in_body), 128'(0));
    cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
